// File: rtl/tube_scan_ctrl.sv
// rtl/tube_scan_ctrl.sv - digit-multiplex scan scheduler and configuration registers for the 7-segment tube
//
// Owns the dwell counter, scan index and one-hot digit selects for tube
// groups 0/1/2, plus software-programmable scan period, PWM brightness and
// leading-zero blanking. The tube data path uses scan_idx to fetch segment
// data; this block only decides which digit is lit and when.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   WE          bus write enable
//   Addr[31:2]  bus word address ({Addr,2'b00} is the byte address)
//   Din[31:0]   bus write data
//   word1[31:0] current 8-nibble display value (used only for blanking)
//   Dout[31:0]  combinational read data for CTRL / PERIOD, 0 elsewhere
//   scan_idx    current digit position 0..3
//   digit_sel0  one-hot select, group 0 (nibbles 0-3)
//   digit_sel1  one-hot select, group 1 (nibbles 4-7)
//   digit_sel2  select for group 2 (single digit)
//   pwm_on      brightness gate

module tube_scan_ctrl #(
    parameter logic [31:0] CTRL_ADDR   = 32'h00007f40,
    parameter logic [31:0] PERIOD_ADDR = 32'h00007f44,
    parameter logic [31:0] PERIOD_RST  = 32'd10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:2] Addr,
    input  logic [31:0] Din,
    input  logic [31:0] word1,
    output logic [31:0] Dout,
    output logic [1:0]  scan_idx,
    output logic [3:0]  digit_sel0,
    output logic [3:0]  digit_sel1,
    output logic        digit_sel2,
    output logic        pwm_on
);

    // Configuration registers
    logic        en_q, en_d;
    logic        lzb_q, lzb_d;
    logic [3:0]  bright_q, bright_d;
    logic [31:0] period_q, period_d;

    // Scan state
    logic [31:0] dwell_q, dwell_d;
    logic [3:0]  pwm_q, pwm_d;
    logic [1:0]  idx_q, idx_d;

    logic        ctrl_hit;
    logic        period_hit;
    logic        ctrl_we;
    logic        period_we;
    logic        scan_stop;

    logic [7:0]  tail_zero;
    logic        blank0;
    logic        blank1;
    logic [3:0]  onehot;

    always_comb begin
        ctrl_hit   = ({Addr, 2'b00} == CTRL_ADDR);
        period_hit = ({Addr, 2'b00} == PERIOD_ADDR);
        ctrl_we    = WE & ctrl_hit;
        period_we  = WE & period_hit;
    end

    // Register file and scan sequencing
    always_comb begin
        en_d     = en_q;
        lzb_d    = lzb_q;
        bright_d = bright_q;
        period_d = period_q;
        dwell_d  = dwell_q;
        pwm_d    = pwm_q;
        idx_d    = idx_q;

        if (ctrl_we) begin
            en_d     = Din[0];
            lzb_d    = Din[1];
            bright_d = Din[5:2];
        end
        if (period_we) begin
            period_d = Din;
        end

        // Disabling parks the scan on the very edge of the CTRL write so the
        // following cycle is already dark at index 0. While off, the dwell
        // counter tracks the (possibly just written) period so re-enabling
        // starts with a full dwell.
        scan_stop = !en_q || (ctrl_we && !Din[0]);

        if (scan_stop) begin
            idx_d   = 2'd0;
            dwell_d = period_d;
            pwm_d   = 4'd0;
        end else begin
            pwm_d = pwm_q + 4'd1;
            if (period_we) begin
                // A period write restarts the current dwell and wins over a
                // coinciding expiry: the index holds this edge.
                dwell_d = Din;
            end else if (dwell_q == 32'd0) begin
                dwell_d = period_q;
                idx_d   = idx_q + 2'd1;
            end else begin
                dwell_d = dwell_q - 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q     <= 1'b1;
            lzb_q    <= 1'b0;
            bright_q <= 4'd15;
            period_q <= PERIOD_RST;
            dwell_q  <= PERIOD_RST;
            pwm_q    <= 4'd0;
            idx_q    <= 2'd0;
        end else begin
            en_q     <= en_d;
            lzb_q    <= lzb_d;
            bright_q <= bright_d;
            period_q <= period_d;
            dwell_q  <= dwell_d;
            pwm_q    <= pwm_d;
            idx_q    <= idx_d;
        end
    end

    // tail_zero[k] is set when nibbles k..7 of word1 are all zero.
    always_comb begin
        tail_zero = 8'd0;
        for (int k = 0; k < 8; k++) begin
            tail_zero[k] = ((word1 >> (4 * k)) == 32'd0);
        end
    end

    always_comb begin
        // Position 0 always shows, so a value of zero still displays "0".
        blank0     = lzb_q && (idx_q != 2'd0) && tail_zero[{1'b0, idx_q}];
        blank1     = lzb_q && tail_zero[{1'b1, idx_q}];
        onehot     = 4'b0001 << idx_q;

        pwm_on     = en_q && (pwm_q <= bright_q);
        scan_idx   = idx_q;
        digit_sel0 = (pwm_on && !blank0) ? onehot : 4'd0;
        digit_sel1 = (pwm_on && !blank1) ? onehot : 4'd0;
        digit_sel2 = pwm_on;
    end

    always_comb begin
        Dout = 32'd0;
        if (ctrl_hit) begin
            Dout = {26'd0, bright_q, lzb_q, en_q};
        end else if (period_hit) begin
            Dout = period_q;
        end
    end

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// tb/tb_tube_scan_ctrl.sv - self-checking bench for tube_scan_ctrl

module tb_tube_scan_ctrl;

    localparam logic [29:0] A_CTRL = 30'h1FD0;
    localparam logic [29:0] A_PER  = 30'h1FD1;
    localparam logic [29:0] A_NONE = 30'h1FD2;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [29:0] addr;
    logic [31:0] din;
    logic [31:0] word1;

    logic [31:0] a_dout;
    logic [1:0]  a_idx;
    logic [3:0]  a_sel0, a_sel1;
    logic        a_sel2, a_pwm;

    logic [31:0] b_dout;
    logic [1:0]  b_idx;
    logic [3:0]  b_sel0, b_sel1;
    logic        b_sel2, b_pwm;

    always #5 clk = ~clk;

    tube_scan_ctrl #(.PERIOD_RST(32'd3)) dut_a (
        .clk(clk), .reset(reset), .WE(we), .Addr(addr), .Din(din), .word1(word1),
        .Dout(a_dout), .scan_idx(a_idx), .digit_sel0(a_sel0), .digit_sel1(a_sel1),
        .digit_sel2(a_sel2), .pwm_on(a_pwm)
    );

    tube_scan_ctrl dut_b (
        .clk(clk), .reset(reset), .WE(we), .Addr(addr), .Din(din), .word1(word1),
        .Dout(b_dout), .scan_idx(b_idx), .digit_sel0(b_sel0), .digit_sel1(b_sel1),
        .digit_sel2(b_sel2), .pwm_on(b_pwm)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model (dut_a, PERIOD_RST=3): digit held while elapsed < period
    logic        m_en;
    logic        m_lzb;
    logic [3:0]  m_bright;
    logic [31:0] m_period;
    logic [31:0] m_elapsed;
    int          m_idx;
    int          m_pwm;

    function automatic logic m_pwm_on();
        return m_en && (m_pwm <= int'(m_bright));
    endfunction

    function automatic logic m_blank(input int k);
        return m_lzb && (k != 0) && ((word1 >> (4 * k)) == 32'd0);
    endfunction

    function automatic logic [3:0] m_sel(input int grp);
        if (m_pwm_on() && !m_blank(4 * grp + m_idx)) return 4'b0001 << m_idx;
        return 4'd0;
    endfunction

    function automatic logic [31:0] m_dout();
        if (addr == A_CTRL) return {26'd0, m_bright, m_lzb, m_en};
        if (addr == A_PER)  return m_period;
        return 32'd0;
    endfunction

    task automatic model_check();
        chk("scan_idx", 32'(a_idx), 32'(m_idx));
        chk("digit_sel0", 32'(a_sel0), 32'(m_sel(0)));
        chk("digit_sel1", 32'(a_sel1), 32'(m_sel(1)));
        chk("digit_sel2", 32'(a_sel2), 32'(m_pwm_on()));
        chk("pwm_on", 32'(a_pwm), 32'(m_pwm_on()));
        chk("dout", a_dout, m_dout());
    endtask

    task automatic model_update();
        logic ctrl_w, per_w, stop;
        if (reset) begin
            m_en = 1'b1; m_lzb = 1'b0; m_bright = 4'd15; m_period = 32'd3;
            m_elapsed = 32'd0; m_idx = 0; m_pwm = 0;
        end else begin
            ctrl_w = we && (addr == A_CTRL);
            per_w  = we && (addr == A_PER);
            stop   = !m_en || (ctrl_w && !din[0]);
            if (ctrl_w) begin
                m_en = din[0]; m_lzb = din[1]; m_bright = din[5:2];
            end
            if (per_w) m_period = din;
            if (stop) begin
                m_idx = 0; m_elapsed = 32'd0; m_pwm = 0;
            end else begin
                m_pwm = (m_pwm + 1) % 16;
                if (per_w) begin
                    m_elapsed = 32'd0;
                end else if (m_elapsed == m_period) begin
                    m_idx = (m_idx + 1) % 4;
                    m_elapsed = 32'd0;
                end else begin
                    m_elapsed = m_elapsed + 32'd1;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [29:0] a,
                         input logic [31:0] d, input logic [31:0] w1);
        reset = r; we = w; addr = a; din = d; word1 = w1;
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, A_CTRL, 32'd0, 32'd0);
        advance();
    endtask

    task automatic idle(input logic [31:0] w1, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, A_CTRL, 32'd0, w1);
            sample();
            advance();
        end
    endtask

    typedef struct {
        logic [31:0] word1;
        logic [1:0]  idx;
        logic [3:0]  sel;
        logic        pwm;
        logic [31:0] dout;
    } vec_t;

    vec_t       tbl[17];
    logic [1:0] seq_idx[17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
    logic [3:0] onehot[4]   = '{4'd1, 4'd2, 4'd4, 4'd8};
    logic [1:0] pw_seq[5]   = '{2,3,0,1,2};

    initial begin
        int cnt;
        logic [29:0] ra;
        logic [31:0] rd;

        m_en = 1'b1; m_lzb = 1'b0; m_bright = 4'd15; m_period = 32'd3;
        m_elapsed = 32'd0; m_idx = 0; m_pwm = 0;

        for (int i = 0; i < 17; i++) begin
            tbl[i].word1 = (i % 3 == 0) ? 32'd0 : 32'h8000_0001 * i;
            tbl[i].idx   = seq_idx[i];
            tbl[i].sel   = onehot[seq_idx[i]];
            tbl[i].pwm   = 1'b1;
            tbl[i].dout  = 32'h3D;
        end

        // Reset held two cycles, then free-running scan from reset values
        drive(1'b1, 1'b0, A_CTRL, 32'd0, 32'd0);
        advance();
        advance();
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'b0, A_CTRL, 32'd0, tbl[i].word1);
            sample();
            chk("tbl_idx", 32'(a_idx), 32'(tbl[i].idx));
            chk("tbl_sel0", 32'(a_sel0), 32'(tbl[i].sel));
            chk("tbl_sel1", 32'(a_sel1), 32'(tbl[i].sel));
            chk("tbl_sel2", 32'(a_sel2), 32'(tbl[i].pwm));
            chk("tbl_pwm", 32'(a_pwm), 32'(tbl[i].pwm));
            chk("tbl_dout", a_dout, tbl[i].dout);
            advance();
        end

        // Period write to 0 mid-dwell at scan_idx=2
        do_reset();
        idle(32'd0, 9);
        drive(1'b0, 1'b1, A_PER, 32'd0, 32'd0);
        sample();
        chk("pw_at_write", 32'(a_idx), 32'd2);
        advance();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, A_PER, 32'd0, 32'd0);
            sample();
            chk("pw_seq", 32'(a_idx), 32'(pw_seq[i]));
            advance();
        end

        // Brightness 3: four of every sixteen cycles lit
        do_reset();
        drive(1'b0, 1'b1, A_PER, 32'd1000, 32'h1);
        sample(); advance();
        drive(1'b0, 1'b1, A_CTRL, 32'h0D, 32'h1);
        sample(); advance();
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, A_CTRL, 32'd0, 32'h1);
            sample();
            if (a_pwm) cnt++;
            else chk("dark_sel", {23'd0, a_sel0, a_sel1, a_sel2}, 32'd0);
            advance();
        end
        chk("bright_duty", 32'(cnt), 32'd8);

        // Leading-zero blanking with period 0
        do_reset();
        drive(1'b0, 1'b1, A_PER, 32'd0, 32'h120);
        sample(); advance();
        drive(1'b0, 1'b1, A_CTRL, 32'h3F, 32'h120);
        sample(); advance();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, A_CTRL, 32'd0, 32'h120);
            sample();
            chk("lzb_g1", 32'(a_sel1), 32'd0);
            chk("lzb_g0", 32'(a_sel0), (m_idx == 3) ? 32'd0 : (32'd1 << m_idx));
            advance();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, A_CTRL, 32'd0, 32'd0);
            sample();
            chk("lzb_zero_g0", 32'(a_sel0), (m_idx == 0) ? 32'd1 : 32'd0);
            chk("lzb_zero_g2", 32'(a_sel2), 32'd1);
            advance();
        end

        // Disable at scan_idx=3, then re-enable
        do_reset();
        idle(32'h5555_5555, 12);
        drive(1'b0, 1'b1, A_CTRL, 32'h3C, 32'h5555_5555);
        sample();
        chk("dis_at_write", 32'(a_idx), 32'd3);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, A_CTRL, 32'd0, 32'h5555_5555);
            sample();
            chk("off_idx", 32'(a_idx), 32'd0);
            chk("off_sel", {23'd0, a_sel0, a_sel1, a_sel2}, 32'd0);
            chk("off_pwm", 32'(a_pwm), 32'd0);
            advance();
        end
        drive(1'b0, 1'b1, A_CTRL, 32'h3D, 32'h5555_5555);
        sample();
        chk("en_write_pwm", 32'(a_pwm), 32'd0);
        advance();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, A_CTRL, 32'd0, 32'h5555_5555);
            sample();
            chk("reen_idx", 32'(a_idx), (i < 4) ? 32'd0 : 32'd1);
            advance();
        end

        // Reset coinciding with a period write
        drive(1'b1, 1'b1, A_PER, 32'd55, 32'd0);
        advance();
        drive(1'b0, 1'b0, A_PER, 32'd0, 32'd0);
        sample();
        chk("rst_wr_a", a_dout, 32'd3);
        chk("rst_wr_b", b_dout, 32'd10000);
        advance();

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = A_CTRL;
                1:       ra = A_PER;
                2:       ra = A_NONE;
                default: ra = 30'd0;
            endcase
            if (ra == A_PER) begin
                rd = 32'($urandom_range(0, 5));
            end else begin
                rd = $urandom;
                if ($urandom_range(0, 4) != 0) rd[0] = 1'b1;
            end
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) == 0), ra, rd,
                  $urandom >> (4 * $urandom_range(0, 8)));
            sample();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
